// File: rtl/ready_bits_update_arb_if.sv
// Requester-side bundle for the ready-bits update arbiter: per-requester
// valid/wfid/payload toward the arbiter and the combinational accept back.
`ifndef ISSUE_GPR_RD_BITS_LENGTH
`define ISSUE_GPR_RD_BITS_LENGTH 8
`endif
`ifndef WF_ID_LENGTH
`define WF_ID_LENGTH 6
`endif
`ifndef WF_PER_CU
`define WF_PER_CU 40
`endif

interface ready_bits_update_arb_if #(
  parameter int NUM_REQ  = 4,
  parameter int INFO_LEN = `ISSUE_GPR_RD_BITS_LENGTH,
  parameter int WF_ID_W  = `WF_ID_LENGTH
) ();
  logic [NUM_REQ-1:0]          req_valid;
  logic [NUM_REQ*WF_ID_W-1:0]  req_wfid;
  logic [NUM_REQ*INFO_LEN-1:0] req_bits;
  logic [NUM_REQ-1:0]          req_ready;

  modport master (output req_valid, output req_wfid, output req_bits, input req_ready);
  modport slave  (input req_valid, input req_wfid, input req_bits, output req_ready);
endinterface

// File: rtl/ready_bits_update_arb.sv
// Round-robin arbiter feeding the ready-bits demux: one winner per cycle,
// same-wavefront requesters merged by OR, registered output, halt/drain control.
`ifndef ISSUE_GPR_RD_BITS_LENGTH
`define ISSUE_GPR_RD_BITS_LENGTH 8
`endif
`ifndef WF_ID_LENGTH
`define WF_ID_LENGTH 6
`endif
`ifndef WF_PER_CU
`define WF_PER_CU 40
`endif

module ready_bits_update_arb #(
  parameter int NUM_REQ  = 4,
  parameter int INFO_LEN = `ISSUE_GPR_RD_BITS_LENGTH,
  parameter int WF_ID_W  = `WF_ID_LENGTH,
  parameter int WF_NUM   = `WF_PER_CU
) (
  input  logic                clk,
  input  logic                rst_n,
  ready_bits_update_arb_if.slave req_if,
  input  logic                halt_req,
  output logic                halted,
  output logic                dmx_en,
  output logic [WF_ID_W-1:0]  dmx_addr,
  output logic [INFO_LEN-1:0] dmx_in,
  output logic                bad_id
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_HALTED = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [PTR_W-1:0]    ptr_q, ptr_d;
  logic                en_q, en_d;
  logic [WF_ID_W-1:0]  addr_q, addr_d;
  logic [INFO_LEN-1:0] in_q, in_d;
  logic                bad_q, bad_d;

  logic                grant_ok;
  logic                found;
  int                  win;
  logic [WF_ID_W-1:0]  win_wfid;
  logic [NUM_REQ-1:0]  merge_mask;
  logic [INFO_LEN-1:0] merge_bits;
  logic                grant;
  logic                legal;

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_RUN;
    else        state_q <= state_d;
  end

  // next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN:    if (halt_req) state_d = ST_DRAIN;
      ST_DRAIN:  state_d = ST_HALTED;
      ST_HALTED: if (!halt_req) state_d = ST_RUN;
      default:   state_d = ST_RUN;
    endcase
  end

  // state outputs
  always_comb begin
    grant_ok = (state_q == ST_RUN) && !halt_req;
    halted   = (state_q == ST_HALTED);
  end

  // round-robin search starting at the pointer
  always_comb begin
    found = 1'b0;
    win   = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      int idx;
      idx = (int'(ptr_q) + k) % NUM_REQ;
      if (!found && req_if.req_valid[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  assign win_wfid = req_if.req_wfid[win*WF_ID_W +: WF_ID_W];

  always_comb begin
    merge_mask = '0;
    merge_bits = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (req_if.req_valid[i] && (req_if.req_wfid[i*WF_ID_W +: WF_ID_W] == win_wfid)) begin
        merge_mask[i] = 1'b1;
        merge_bits    = merge_bits | req_if.req_bits[i*INFO_LEN +: INFO_LEN];
      end
    end
  end

  assign grant            = grant_ok && found;
  assign legal            = int'(win_wfid) < WF_NUM;
  assign req_if.req_ready = grant ? merge_mask : '0;

  // illegal ids are consumed but never reach the demux; addr/payload hold
  always_comb begin
    ptr_d  = grant ? PTR_W'((win + 1) % NUM_REQ) : ptr_q;
    en_d   = grant && legal;
    bad_d  = grant && !legal;
    addr_d = en_d ? win_wfid : addr_q;
    in_d   = en_d ? merge_bits : in_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q  <= '0;
      en_q   <= 1'b0;
      addr_q <= '0;
      in_q   <= '0;
      bad_q  <= 1'b0;
    end else begin
      ptr_q  <= ptr_d;
      en_q   <= en_d;
      addr_q <= addr_d;
      in_q   <= in_d;
      bad_q  <= bad_d;
    end
  end

  assign dmx_en   = en_q;
  assign dmx_addr = addr_q;
  assign dmx_in   = in_q;
  assign bad_id   = bad_q;

endmodule

// File: tb/tb_ready_bits_update_arb.sv
// Directed vector bench for ready_bits_update_arb: each row drives inputs, checks
// the combinational accept and the outputs registered from the previous row.
module tb_ready_bits_update_arb;

  logic       clk;
  logic       rst_n;
  logic       halt_req;
  logic       halted;
  logic       dmx_en;
  logic [5:0] dmx_addr;
  logic [7:0] dmx_in;
  logic       bad_id;

  int checks = 0;
  int errors = 0;

  ready_bits_update_arb_if #(.NUM_REQ(4), .INFO_LEN(8), .WF_ID_W(6)) rif ();

  ready_bits_update_arb #(.NUM_REQ(4), .INFO_LEN(8), .WF_ID_W(6), .WF_NUM(40)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_if   (rif.slave),
    .halt_req (halt_req),
    .halted   (halted),
    .dmx_en   (dmx_en),
    .dmx_addr (dmx_addr),
    .dmx_in   (dmx_in),
    .bad_id   (bad_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  v;
    logic [23:0] w;
    logic [31:0] b;
    logic        halt;
    logic [3:0]  rdy;
    logic        en;
    logic [5:0]  addr;
    logic [7:0]  din;
    logic        bad;
    logic        hlt;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic [3:0] v,
                              input logic [5:0] w0, input logic [5:0] w1,
                              input logic [5:0] w2, input logic [5:0] w3,
                              input logic [7:0] b0, input logic [7:0] b1,
                              input logic [7:0] b2, input logic [7:0] b3,
                              input logic halt, input logic [3:0] rdy,
                              input logic en, input logic [5:0] addr,
                              input logic [7:0] din, input logic bad,
                              input logic hlt);
    vec_t r;
    r.v = v; r.w = {w3, w2, w1, w0}; r.b = {b3, b2, b1, b0};
    r.halt = halt; r.rdy = rdy; r.en = en; r.addr = addr;
    r.din = din; r.bad = bad; r.hlt = hlt;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [3:0] v, input logic [23:0] w, input logic [31:0] b,
                       input logic halt);
    rif.req_valid = v;
    rif.req_wfid  = w;
    rif.req_bits  = b;
    halt_req      = halt;
  endtask

  initial begin
    rst_n = 1'b0;
    drive(4'b0, '0, '0, 1'b0);

    // idle
    tbl.push_back(mk(4'b0000, 0,0,0,0, 8'h00,8'h00,8'h00,8'h00, 0, 4'b0000, 0, 0, 8'h00, 0, 0));
    // fairness: distinct wfids 1..4 held
    tbl.push_back(mk(4'b1111, 1,2,3,4, 8'h01,8'h02,8'h04,8'h08, 0, 4'b0001, 0, 0, 8'h00, 0, 0));
    tbl.push_back(mk(4'b1111, 1,2,3,4, 8'h01,8'h02,8'h04,8'h08, 0, 4'b0010, 1, 1, 8'h01, 0, 0));
    tbl.push_back(mk(4'b1111, 1,2,3,4, 8'h01,8'h02,8'h04,8'h08, 0, 4'b0100, 1, 2, 8'h02, 0, 0));
    tbl.push_back(mk(4'b1111, 1,2,3,4, 8'h01,8'h02,8'h04,8'h08, 0, 4'b1000, 1, 3, 8'h04, 0, 0));
    tbl.push_back(mk(4'b1111, 1,2,3,4, 8'h01,8'h02,8'h04,8'h08, 0, 4'b0001, 1, 4, 8'h08, 0, 0));
    tbl.push_back(mk(4'b1111, 1,2,3,4, 8'h01,8'h02,8'h04,8'h08, 0, 4'b0010, 1, 1, 8'h01, 0, 0));
    tbl.push_back(mk(4'b1111, 1,2,3,4, 8'h01,8'h02,8'h04,8'h08, 0, 4'b0100, 1, 2, 8'h02, 0, 0));
    tbl.push_back(mk(4'b1111, 1,2,3,4, 8'h01,8'h02,8'h04,8'h08, 0, 4'b1000, 1, 3, 8'h04, 0, 0));
    // merge req0/req2 on wfid 5
    tbl.push_back(mk(4'b0101, 5,0,5,0, 8'h01,8'h00,8'h10,8'h00, 0, 4'b0101, 1, 4, 8'h08, 0, 0));
    tbl.push_back(mk(4'b0000, 0,0,0,0, 8'h00,8'h00,8'h00,8'h00, 0, 4'b0000, 1, 5, 8'h11, 0, 0));
    // bad id 45
    tbl.push_back(mk(4'b0010, 0,45,0,0, 8'h00,8'hAA,8'h00,8'h00, 0, 4'b0010, 0, 5, 8'h11, 0, 0));
    tbl.push_back(mk(4'b0000, 0,0,0,0, 8'h00,8'h00,8'h00,8'h00, 0, 4'b0000, 0, 5, 8'h11, 1, 0));
    tbl.push_back(mk(4'b0000, 0,0,0,0, 8'h00,8'h00,8'h00,8'h00, 0, 4'b0000, 0, 5, 8'h11, 0, 0));
    // boundary 39 then 40
    tbl.push_back(mk(4'b1000, 0,0,0,39, 8'h00,8'h00,8'h00,8'h33, 0, 4'b1000, 0, 5, 8'h11, 0, 0));
    tbl.push_back(mk(4'b0001, 40,0,0,0, 8'h44,8'h00,8'h00,8'h00, 0, 4'b0001, 1, 39, 8'h33, 0, 0));
    tbl.push_back(mk(4'b0000, 0,0,0,0, 8'h00,8'h00,8'h00,8'h00, 0, 4'b0000, 0, 39, 8'h33, 1, 0));
    // sparse round robin
    tbl.push_back(mk(4'b1010, 0,9,0,10, 8'h00,8'h21,8'h00,8'h22, 0, 4'b0010, 0, 39, 8'h33, 0, 0));
    tbl.push_back(mk(4'b1010, 0,9,0,10, 8'h00,8'h21,8'h00,8'h22, 0, 4'b1000, 1, 9, 8'h21, 0, 0));
    tbl.push_back(mk(4'b0000, 0,0,0,0, 8'h00,8'h00,8'h00,8'h00, 0, 4'b0000, 1, 10, 8'h22, 0, 0));
    // halt right after a grant to wfid 7
    tbl.push_back(mk(4'b0001, 7,0,0,0, 8'h07,8'h00,8'h00,8'h00, 0, 4'b0001, 0, 10, 8'h22, 0, 0));
    tbl.push_back(mk(4'b0110, 0,2,3,0, 8'h00,8'h02,8'h03,8'h00, 1, 4'b0000, 1, 7, 8'h07, 0, 0));
    tbl.push_back(mk(4'b0110, 0,2,3,0, 8'h00,8'h02,8'h03,8'h00, 1, 4'b0000, 0, 7, 8'h07, 0, 0));
    tbl.push_back(mk(4'b0110, 0,2,3,0, 8'h00,8'h02,8'h03,8'h00, 1, 4'b0000, 0, 7, 8'h07, 0, 1));
    tbl.push_back(mk(4'b0110, 0,2,3,0, 8'h00,8'h02,8'h03,8'h00, 0, 4'b0000, 0, 7, 8'h07, 0, 1));
    tbl.push_back(mk(4'b0110, 0,2,3,0, 8'h00,8'h02,8'h03,8'h00, 0, 4'b0010, 0, 7, 8'h07, 0, 0));
    tbl.push_back(mk(4'b0000, 0,0,0,0, 8'h00,8'h00,8'h00,8'h00, 0, 4'b0000, 1, 2, 8'h02, 0, 0));
    // halt dropped during drain: full sequence still runs
    tbl.push_back(mk(4'b0001, 8,0,0,0, 8'h08,8'h00,8'h00,8'h00, 1, 4'b0000, 0, 2, 8'h02, 0, 0));
    tbl.push_back(mk(4'b0001, 8,0,0,0, 8'h08,8'h00,8'h00,8'h00, 0, 4'b0000, 0, 2, 8'h02, 0, 0));
    tbl.push_back(mk(4'b0001, 8,0,0,0, 8'h08,8'h00,8'h00,8'h00, 0, 4'b0000, 0, 2, 8'h02, 0, 1));
    tbl.push_back(mk(4'b0001, 8,0,0,0, 8'h08,8'h00,8'h00,8'h00, 0, 4'b0001, 0, 2, 8'h02, 0, 0));
    tbl.push_back(mk(4'b0000, 0,0,0,0, 8'h00,8'h00,8'h00,8'h00, 0, 4'b0000, 1, 8, 8'h08, 0, 0));

    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    foreach (tbl[r]) begin
      drive(tbl[r].v, tbl[r].w, tbl[r].b, tbl[r].halt);
      #1;
      chk($sformatf("row%0d req_ready", r), 32'(rif.req_ready), 32'(tbl[r].rdy));
      chk($sformatf("row%0d dmx_en",    r), 32'(dmx_en),        32'(tbl[r].en));
      chk($sformatf("row%0d dmx_addr",  r), 32'(dmx_addr),      32'(tbl[r].addr));
      chk($sformatf("row%0d dmx_in",    r), 32'(dmx_in),        32'(tbl[r].din));
      chk($sformatf("row%0d bad_id",    r), 32'(bad_id),        32'(tbl[r].bad));
      chk($sformatf("row%0d halted",    r), 32'(halted),        32'(tbl[r].hlt));
      @(negedge clk);
    end

    // reset while the output register holds an update
    drive(4'b0001, {6'd0, 6'd0, 6'd0, 6'd12}, {8'h00, 8'h00, 8'h00, 8'h5A}, 1'b0);
    #1;
    chk("rst_pre req_ready", 32'(rif.req_ready), 32'h1);
    @(posedge clk);
    #2;
    chk("rst_pre dmx_en",   32'(dmx_en),   32'h1);
    chk("rst_pre dmx_addr", 32'(dmx_addr), 32'd12);
    rst_n = 1'b0;
    #1;
    chk("rst_async dmx_en",   32'(dmx_en),   32'h0);
    chk("rst_async dmx_addr", 32'(dmx_addr), 32'h0);
    chk("rst_async dmx_in",   32'(dmx_in),   32'h0);
    chk("rst_async bad_id",   32'(bad_id),   32'h0);
    chk("rst_async halted",   32'(halted),   32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    // pointer must be back at 0: req0 wins over req3
    drive(4'b1001, {6'd14, 6'd0, 6'd0, 6'd13}, {8'h77, 8'h00, 8'h00, 8'h3C}, 1'b0);
    #1;
    chk("rel req_ready", 32'(rif.req_ready), 32'h1);
    chk("rel dmx_en",    32'(dmx_en),        32'h0);
    @(posedge clk);
    #1;
    drive(4'b0000, '0, '0, 1'b0);
    chk("rel1 dmx_en",   32'(dmx_en),   32'h1);
    chk("rel1 dmx_addr", 32'(dmx_addr), 32'd13);
    chk("rel1 dmx_in",   32'(dmx_in),   32'h3C);
    @(posedge clk);
    #1;
    chk("rel2 dmx_en", 32'(dmx_en), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ready_bits_update_arb.md
READY_BITS_UPDATE_ARB -- requirements
Module: ready_bits_update_arb

Interface
REQ-001 Parameter NUM_REQ, default 4, number of update requesters sharing the ready-bits demux.
REQ-002 Parameter INFO_LEN, default `ISSUE_GPR_RD_BITS_LENGTH, width of one ready-bits update.
REQ-003 Parameter WF_ID_W, default `WF_ID_LENGTH (6), wavefront id width.
REQ-004 Parameter WF_NUM, default `WF_PER_CU (40), number of valid wavefront ids (0..WF_NUM-1).
REQ-005 Port: clk, input, 1, the single clock; all state changes on its rising edge.
REQ-006 Port: rst_n, input, 1, asynchronous active-low reset.
REQ-007 Port: req_valid, input, NUM_REQ, per-requester update valid.
REQ-008 Port: req_wfid, input, NUM_REQ*WF_ID_W, per-requester target wavefront id, requester i at slice i.
REQ-009 Port: req_bits, input, NUM_REQ*INFO_LEN, per-requester ready-bits payload, requester i at slice i.
REQ-010 Port: req_ready, output, NUM_REQ, per-requester accept; a transfer occurs when req_valid[i] & req_ready[i].
REQ-011 Port: halt_req, input, 1, level request to stop accepting updates and drain.
REQ-012 Port: halted, output, 1, high while the block is stopped and drained.
REQ-013 Port: dmx_en, output, 1, enable to the ready-bits demux.
REQ-014 Port: dmx_addr, output, WF_ID_W, wavefront id to the demux.
REQ-015 Port: dmx_in, output, INFO_LEN, ready-bits payload to the demux.
REQ-016 Port: bad_id, output, 1, one-cycle pulse when an accepted update carried wfid >= WF_NUM.

Function
REQ-017 FSM states RUN, DRAIN, HALTED; transitions are evaluated every cycle.
REQ-018 RUN: at most one winner per cycle is chosen round-robin among asserted req_valid, starting from the index after the previous winner.
REQ-019 Same-wavefront merge: every valid requester whose req_wfid equals the winner's req_wfid is accepted in that cycle too, and the payloads are bitwise ORed.
REQ-020 req_ready is combinational: high in RUN only for the winner and its merged requesters; low in DRAIN and HALTED.
REQ-021 The round-robin pointer advances to winner+1 (mod NUM_REQ) only on a grant; merged requesters do not move it.
REQ-022 Output register: 1-cycle latency; the cycle after acceptance, dmx_en=1, dmx_addr=wfid, dmx_in=merged payload; with no acceptance, dmx_en=0 and dmx_addr/dmx_in hold their last values.
REQ-023 Illegal id: an accepted update with wfid >= WF_NUM is consumed, gives dmx_en=0, and pulses bad_id the following cycle.
REQ-024 RUN -> DRAIN when halt_req=1; no grant is made in that cycle, and the output register still presents the previous cycle's update.
REQ-025 DRAIN -> HALTED after one cycle, once the output register is empty; halted=1 in HALTED only.
REQ-026 HALTED -> RUN when halt_req=0; grants resume on the next cycle with the pointer preserved.
REQ-027 halt_req deasserted while in DRAIN: the DRAIN -> HALTED -> RUN sequence still completes; no shortcut.
REQ-028 Requests that are not accepted are not stored; requesters hold valid and payload until accepted.

Reset
REQ-029 Asynchronous assertion of rst_n=0 immediately forces: state RUN, pointer 0, dmx_en=0, dmx_addr=0, dmx_in=0, bad_id=0, halted=0.
REQ-030 Reset mid-transfer discards the registered update; no dmx_en pulse follows reset release.
REQ-031 Reset is released synchronously to clk; the first grant is possible in the first cycle after release.

Verification
REQ-032 Fairness: all 4 requesters valid, distinct wfids 1,2,3,4, held for 8 cycles -> grants in order 0,1,2,3,0,1,2,3; dmx_addr sequence 1,2,3,4,1,2,3,4, one cycle after each grant.
REQ-033 Merge: req0 wfid 5, bits 0x01; req2 wfid 5, bits 0x10; both valid -> req_ready=0101; next cycle dmx_en=1, dmx_addr=5, dmx_in=0x11.
REQ-034 Bad id: req1 valid with wfid 45 alone -> req_ready[1]=1; next cycle dmx_en=0 and bad_id=1 for exactly one cycle.
REQ-035 Halt: halt_req rises the cycle after a grant to wfid 7 -> dmx_en=1 for wfid 7 in that cycle; halted=1 two cycles after halt_req rose; req_ready=0 throughout; halt_req low -> grants resume at the saved pointer.
REQ-036 Reset: rst_n pulsed low mid-cycle while the output register holds an update -> dmx_en=0 at once, asynchronously; no update appears after release.
REQ-037 Boundary: wfid 39 accepted -> dmx_addr=39, dmx_en=1; wfid 40 accepted -> bad_id pulse.
